// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: shared widths, BRAM depth, addressing mode and FSM state encoding
package dmem_access_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int MEM_DEPTH = 400001;
  localparam bit BYTE_ADDR = 1'b1;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: bundles the pipeline req/rsp handshake and BRAM port; modports master (core), slave (controller), mem (BRAM)
interface dmem_access_ctrl_if;
  import dmem_access_ctrl_pkg::*;
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic rsp_err;
  logic mem_en;
  logic mem_we;
  logic [31:0] mem_addr;
  logic [DATA_W-1:0] mem_di;
  logic [DATA_W-1:0] mem_dout;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_di
  );
  modport mem (
    input mem_en, mem_we, mem_addr, mem_di,
    output mem_dout
  );
endinterface

// File: rtl/dmem_access_ctrl_addr_check.sv
// dmem_access_ctrl_addr_check: maps req address (in addr) to BRAM word index (out word) and flags misaligned/out-of-range (out bad)
module dmem_access_ctrl_addr_check
  import dmem_access_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = dmem_access_ctrl_pkg::MEM_DEPTH,
  parameter bit BYTE_ADDR = dmem_access_ctrl_pkg::BYTE_ADDR
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       word,
  output logic              bad
);
  always_comb begin
    word = BYTE_ADDR ? 32'(addr >> 2) : 32'(addr);
    bad = (BYTE_ADDR && addr[1:0] != 2'b00) || word >= 32'(MEM_DEPTH);
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store initiator for a read-first 1-cycle BRAM; clk, rst, bus (slave: req/rsp handshake in, BRAM en/we/addr/di out, dout in)
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = dmem_access_ctrl_pkg::MEM_DEPTH,
  parameter bit BYTE_ADDR = dmem_access_ctrl_pkg::BYTE_ADDR
) (
  input logic clk,
  input logic rst,
  dmem_access_ctrl_if.slave bus
);
  state_t state_q, state_d;
  logic err_q, herr_q, bad, accept, resp, hold;
  logic [DATA_W-1:0] hold_q, rdata_now;
  logic [31:0] word;
  dmem_access_ctrl_addr_check #(.MEM_DEPTH(MEM_DEPTH), .BYTE_ADDR(BYTE_ADDR)) u_chk (
    .addr(bus.req_addr),
    .word(word),
    .bad (bad)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q <= 1'b0;
      herr_q <= 1'b0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) err_q <= bad;
      if (resp && !bus.rsp_ready) begin
        hold_q <= rdata_now;
        herr_q <= err_q;
      end
    end
  end
  always_comb begin
    state_d = accept ? ST_RESP
            : (state_q == ST_RESP || state_q == ST_HOLD) ? (bus.rsp_ready ? ST_IDLE : ST_HOLD)
            : ST_IDLE;
  end
  always_comb begin
    resp = !rst && state_q == ST_RESP;
    hold = !rst && state_q == ST_HOLD;
    rdata_now = err_q ? '0 : bus.mem_dout;
    bus.rsp_valid = resp || hold;
    bus.rsp_rdata = resp ? rdata_now : hold ? hold_q : '0;
    bus.rsp_err = resp ? err_q : hold ? herr_q : 1'b0;
    bus.req_ready = !rst && (state_q == ST_IDLE || (bus.rsp_valid && bus.rsp_ready));
    accept = bus.req_valid && bus.req_ready;
    bus.mem_en = accept && !bad;
    bus.mem_we = bus.mem_en && bus.req_we;
    bus.mem_addr = word;
    bus.mem_di = bus.req_wdata;
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed self-checking bench with a read-first BRAM model
module tb_dmem_access_ctrl;
  localparam int DEPTH = 400001;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [int];
  dmem_access_ctrl_if bus ();
  dmem_access_ctrl #(.MEM_DEPTH(DEPTH), .BYTE_ADDR(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_dout <= mem.exists(int'(bus.mem_addr)) ? mem[int'(bus.mem_addr)] : 32'h0;
      if (bus.mem_we) mem[int'(bus.mem_addr)] = bus.mem_di;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = v;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_wdata = d;
    #1;
  endtask
  function automatic logic [31:0] sdat(input int i);
    return 32'h5A5A_0000 | (32'(i) * 32'h111);
  endfunction
  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    req(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    chk("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", {31'b0, bus.req_ready}, 32'd1);
    req(1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    chk("t1_mem_en", {31'b0, bus.mem_en}, 32'd1);
    chk("t1_mem_we", {31'b0, bus.mem_we}, 32'd1);
    chk("t1_mem_addr", bus.mem_addr, 32'd16);
    chk("t1_mem_di", bus.mem_di, 32'hDEADBEEF);
    tick();
    req(1'b1, 1'b0, 32'h40, 32'h0);
    chk("t1_st_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("t1_st_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("t1_ld_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("t1_ld_mem_en", {31'b0, bus.mem_en}, 32'd1);
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t1_ld_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("t1_ld_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    chk("t1_ld_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    tick();
    chk("t1_idle_valid", {31'b0, bus.rsp_valid}, 32'd0);
    req(1'b1, 1'b1, 32'h80, 32'h11111111);
    tick();
    req(1'b1, 1'b1, 32'h80, 32'h22222222);
    chk("t2_first_rdata", bus.rsp_rdata, 32'h0);
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t2_second_rdata", bus.rsp_rdata, 32'h11111111);
    chk("t2_second_err", {31'b0, bus.rsp_err}, 32'd0);
    tick();
    bus.rsp_ready = 1'b0;
    req(1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    req(1'b1, 1'b0, 32'h80, 32'h0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t3_stall%0d_valid", c), {31'b0, bus.rsp_valid}, 32'd1);
      chk($sformatf("t3_stall%0d_rdata", c), bus.rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("t3_stall%0d_ready", c), {31'b0, bus.req_ready}, 32'd0);
      chk($sformatf("t3_stall%0d_mem_en", c), {31'b0, bus.mem_en}, 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("t3_rel_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    chk("t3_rel_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("t3_rel_mem_en", {31'b0, bus.mem_en}, 32'd1);
    chk("t3_rel_mem_addr", bus.mem_addr, 32'd32);
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t3_next_rdata", bus.rsp_rdata, 32'h22222222);
    tick();
    req(1'b1, 1'b0, 32'h42, 32'h0);
    chk("t4_mis_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("t4_mis_req_ready", {31'b0, bus.req_ready}, 32'd1);
    tick();
    req(1'b1, 1'b0, 32'(4 * DEPTH), 32'h0);
    chk("t4_mis_err", {31'b0, bus.rsp_err}, 32'd1);
    chk("t4_mis_rdata", bus.rsp_rdata, 32'h0);
    chk("t4_oor_mem_en", {31'b0, bus.mem_en}, 32'd0);
    tick();
    req(1'b1, 1'b1, 32'(4 * (DEPTH - 1)), 32'h77);
    chk("t4_oor_err", {31'b0, bus.rsp_err}, 32'd1);
    chk("t4_oor_rdata", bus.rsp_rdata, 32'h0);
    chk("t4_last_mem_en", {31'b0, bus.mem_en}, 32'd1);
    chk("t4_last_mem_addr", bus.mem_addr, 32'(DEPTH - 1));
    tick();
    req(1'b1, 1'b1, 32'h43, 32'h99);
    chk("t4_last_err", {31'b0, bus.rsp_err}, 32'd0);
    chk("t4_mis_st_mem_we", {31'b0, bus.mem_we}, 32'd0);
    tick();
    req(1'b1, 1'b1, 32'h100, 32'hCAFEF00D);
    chk("t4_mis_st_err", {31'b0, bus.rsp_err}, 32'd1);
    tick();
    req(1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    rst = 1'b1;
    req(1'b1, 1'b1, 32'h100, 32'h0BADBAD0);
    chk("t5_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("t5_rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("t5_rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("t5_rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    tick();
    rst = 1'b0;
    req(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t5_discard_valid", {31'b0, bus.rsp_valid}, 32'd0);
    req(1'b1, 1'b0, 32'h100, 32'h0);
    tick();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t5_prior_rdata", bus.rsp_rdata, 32'hCAFEF00D);
    tick();
    for (int i = 0; i < 8; i++) begin
      req(1'b1, 1'b1, 32'h200 + 32'(4 * i), sdat(i));
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      req(1'b1, 1'b0, 32'h200 + 32'(4 * i), 32'h0);
      if (i > 0) begin
        chk($sformatf("t6_ld%0d_valid", i - 1), {31'b0, bus.rsp_valid}, 32'd1);
        chk($sformatf("t6_ld%0d_rdata", i - 1), bus.rsp_rdata, sdat(i - 1));
      end
      tick();
    end
    req(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t6_ld7_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("t6_ld7_rdata", bus.rsp_rdata, sdat(7));
    tick();
    chk("t6_end_idle", {31'b0, bus.rsp_valid}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
